// File: rtl/tran_to_net_packetizer_pkg.sv
// Shared definitions for the transport-to-network packetizer:
// FSM state encoding, header byte position and count-width helper.
package tran_net_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_PAD   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_FILL  = S_FILL,
    ST_PAD   = S_PAD,
    ST_DRAIN = S_DRAIN
  } state_t;

  // Position of the destination (phone number) byte within a burst.
  localparam int HDR_IDX = 0;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tran_to_net_packetizer_if.sv
// Bundle of the transport-side and network-side signals of the packetizer.
// master = transport/network agents, slave = the packetizer itself.
interface tran_to_net_packetizer_if #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int PACKET_SIZE = 16,
  parameter int FIFO_DEPTH  = 64
);
  localparam int LEN_W = tran_net_pkg::cnt_w(PACKET_SIZE);
  localparam int CNT_W = tran_net_pkg::cnt_w(FIFO_DEPTH);

  logic [DATA_W-1:0] data;
  logic              sending;
  logic              in_ready;
  logic              net_rd;
  logic [DATA_W-1:0] packet_out;
  logic              send_data;
  logic [ADDR_W-1:0] phone_num;
  logic [LEN_W-1:0]  pkt_len;
  logic [CNT_W-1:0]  buf_count;
  logic              buf_empty;
  logic              overflow;

  modport master (
    output data, sending, net_rd,
    input  in_ready, packet_out, send_data, phone_num, pkt_len,
           buf_count, buf_empty, overflow
  );

  modport slave (
    input  data, sending, net_rd,
    output in_ready, packet_out, send_data, phone_num, pkt_len,
           buf_count, buf_empty, overflow
  );

endinterface

// File: rtl/tran_to_net_packetizer_pkt_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// dout whenever the FIFO is non-empty; dout reads as zero when empty so the
// network side never sees stale or undefined data.
module pkt_sync_fifo
  import tran_net_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           din,
  input  logic                        wr_en,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           dout,
  output logic [cnt_w(FIFO_DEPTH)-1:0] count,
  output logic                        empty,
  output logic                        full
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = cnt_w(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_wr;
  logic              w_rd;

  // Writes are refused when full and reads when empty, so occupancy can
  // never wrap past either end.
  assign w_wr  = wr_en & ~full;
  assign w_rd  = rd_en & ~empty;
  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign count = r_count;
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tran_to_net_packetizer.sv
// Transport-to-network packetizer. Collects a byte burst (first byte is the
// destination phone number) into a FIFO, closes the packet when it reaches
// PACKET_SIZE bytes or when the burst ends early, then lets the network side
// pop it out. Optional feature macro: TRAN_TO_NET_PAD_SHORT_EN zero-pads a
// short packet up to PACKET_SIZE before it is offered for draining.
module tran_to_net_packetizer
  import tran_net_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PACKET_SIZE = 16,
  parameter int FIFO_DEPTH  = 64,
  parameter int ADDR_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  tran_to_net_packetizer_if.slave  bus
);
  localparam int LEN_W = cnt_w(PACKET_SIZE);
  localparam int CNT_W = cnt_w(FIFO_DEPTH);
  localparam logic [LEN_W-1:0] PKT_LAST = LEN_W'(PACKET_SIZE - 1);

  state_t            r_state;
  logic              r_in_ready;
  logic              r_send_data;
  logic              r_overflow;
  logic [ADDR_W-1:0] r_phone_num;
  logic [LEN_W-1:0]  r_pkt_len;
`ifdef TRAN_TO_NET_PAD_SHORT_EN
  logic [LEN_W-1:0]  r_pad_len;
`endif

  logic              w_wr_acc;
  logic              w_fifo_wr;
  logic [DATA_W-1:0] w_fifo_din;
  logic              w_fifo_rd;
  logic [DATA_W-1:0] w_dout;
  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_full;

  // A byte is taken only while the block advertises readiness; reads are
  // honoured only while a completed packet is draining.
  assign w_wr_acc  = bus.sending & r_in_ready & ~w_full;
  assign w_fifo_rd = (r_state == ST_DRAIN) & bus.net_rd & ~w_empty;
`ifdef TRAN_TO_NET_PAD_SHORT_EN
  assign w_fifo_wr  = w_wr_acc | (r_state == ST_PAD);
  assign w_fifo_din = (r_state == ST_PAD) ? '0 : bus.data;
`else
  assign w_fifo_wr  = w_wr_acc;
  assign w_fifo_din = bus.data;
`endif

  pkt_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .din   (w_fifo_din),
    .wr_en (w_fifo_wr),
    .rd_en (w_fifo_rd),
    .dout  (w_dout),
    .count (w_count),
    .empty (w_empty),
    .full  (w_full)
  );

  // Packet FSM with registered handshake/status outputs, length counter and
  // header latch; reset discards any partially built packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_send_data <= 1'b0;
      r_overflow  <= 1'b0;
      r_phone_num <= '0;
      r_pkt_len   <= '0;
`ifdef TRAN_TO_NET_PAD_SHORT_EN
      r_pad_len   <= '0;
`endif
    end else begin
      // Any byte offered while not ready is lost; remember that forever.
      if (bus.sending && !r_in_ready) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= w_empty;
          if (w_wr_acc) begin
            r_phone_num <= bus.data[ADDR_W-1:0];
            r_pkt_len   <= LEN_W'(HDR_IDX + 1);
            r_in_ready  <= 1'b1;
            r_state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_wr_acc) begin
            r_pkt_len <= r_pkt_len + 1'b1;
            if (r_pkt_len == PKT_LAST) begin
              r_in_ready  <= 1'b0;
              r_send_data <= 1'b1;
              r_state     <= ST_DRAIN;
            end
          end else if (!bus.sending) begin
            // Burst ended early: close the packet at its current length.
            r_in_ready <= 1'b0;
`ifdef TRAN_TO_NET_PAD_SHORT_EN
            r_pad_len  <= r_pkt_len;
            r_state    <= ST_PAD;
`else
            r_send_data <= 1'b1;
            r_state     <= ST_DRAIN;
`endif
          end
        end
`ifdef TRAN_TO_NET_PAD_SHORT_EN
        ST_PAD: begin
          // One zero byte per cycle; pkt_len keeps the unpadded length.
          r_pad_len <= r_pad_len + 1'b1;
          if (r_pad_len == PKT_LAST) begin
            r_send_data <= 1'b1;
            r_state     <= ST_DRAIN;
          end
        end
`endif
        ST_DRAIN: begin
          if (w_fifo_rd && (w_count == CNT_W'(1))) begin
            r_send_data <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_send_data <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.send_data  = r_send_data;
  assign bus.overflow   = r_overflow;
  assign bus.phone_num  = r_phone_num;
  assign bus.pkt_len    = r_pkt_len;
  assign bus.packet_out = w_dout;
  assign bus.buf_count  = w_count;
  assign bus.buf_empty  = w_empty;

endmodule

// File: doc/tran_to_net_packetizer.md
Name: tran_to_net_packetizer

Overview:
- Parametrised successor to the transport-to-network byte path.
- Accepts a byte stream from the transport layer; the first byte of each burst is the destination phone number.
- Buffers the burst into fixed-size packets in an internal FWFT FIFO, then hands each packet to the network layer under a pop handshake.
- Adds flow control, short-packet termination, overflow flagging and packet-length reporting.

Parameters:
- DATA_W, 8, width of transport/network data bytes.
- PACKET_SIZE, 16, bytes per full packet, header byte included. Must be ≥2.
- FIFO_DEPTH, 64, buffer entries. Power of 2, ≥PACKET_SIZE.
- ADDR_W, 8, width of the phone-number field. ≤DATA_W; taken from the header byte LSBs.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- data  in  DATA_W  transport byte.
- sending  in  1  transport byte valid; high for the whole burst.
- in_ready  out  1  block accepts data this cycle.
- net_rd  in  1  network pops the FIFO head.
- packet_out  out  DATA_W  FIFO head (FWFT); valid while !buf_empty.
- send_data  out  1  packet complete and draining.
- phone_num  out  ADDR_W  destination latched from the header.
- pkt_len  out  clog2(PACKET_SIZE+1)  byte count of the current/last packet.
- buf_count  out  clog2(FIFO_DEPTH+1)  FIFO occupancy.
- buf_empty  out  1  FIFO empty.
- overflow  out  1  sticky: a byte was offered while in_ready=0.

Behaviour:
- Reset values:
  - state=IDLE.
  - in_ready=0.
  - send_data=0.
  - phone_num=0, pkt_len=0, overflow=0.
  - FIFO flushed: buf_count=0, buf_empty=1.
  - Reset mid-packet discards all buffered data; no partial drain.
- A write occurs on any cycle with sending & in_ready.
- IDLE:
  - in_ready=buf_empty.
  - On a write: phone_num<=data[ADDR_W-1:0]; the byte is also written to the FIFO; pkt_len<=1; go to FILL.
- FILL:
  - in_ready=1.
  - Each write: pkt_len+1.
  - When the write makes pkt_len==PACKET_SIZE, go to DRAIN next cycle.
  - sending=0 in FILL (short packet): go to DRAIN with the current pkt_len.
- DRAIN:
  - send_data=1 from the cycle after the terminating write.
  - in_ready=0.
  - net_rd pops one entry per cycle.
  - When the pop empties the FIFO, go to IDLE; send_data=0 on the next cycle.
  - pkt_len holds its value until the next header.
- Handshake and boundary rules:
  - net_rd while buf_empty: ignored; no underflow, no count change.
  - net_rd outside DRAIN: ignored.
  - sending=1 while in_ready=0: byte dropped; overflow<=1 (cleared only by reset).
  - FIFO full cannot occur during FILL (FIFO_DEPTH≥PACKET_SIZE). The FIFO still gates writes on full as a safeguard.
  - A simultaneous write and pop cannot occur (disjoint states).
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - buf_count updates one cycle after the write/pop.
  - Header-only burst (sending high 1 cycle): pkt_len=1; the packet drains 1 byte.

Optional Feature:
- Macro: TRAN_TO_NET_PAD_SHORT_EN.
- Defined: a short packet is zero-padded to PACKET_SIZE before DRAIN.
  - Adds a PAD state: one zero byte per cycle, in_ready=0.
  - pkt_len reports the unpadded length.
  - send_data asserts after the last pad byte.
- Undefined: short packets drain at their actual length; no PAD state.

Decomposition:
- Package tran_net_pkg:
  - State encoding localparams (IDLE, FILL, PAD, DRAIN).
  - Header byte index constant (0).
  - Width helper function for count widths.
- One sub-module: pkt_sync_fifo.
  - Parametrised DATA_W/FIFO_DEPTH, synchronous FWFT FIFO.
  - Ports: din, wr_en, rd_en, dout, count, empty, full, with clk/reset.
- The FSM, length counter and phone latch stay in the top module.

Test Plan:
1. Full packet: reset, then sending=1 for 16 cycles with data 0x2A,0x01..0x0F → phone_num=0x2A, pkt_len=16, send_data=1 one cycle after the 16th byte, buf_count=16. Pop 16 times → bytes 0x2A,0x01..0x0F in order, buf_empty=1, send_data=0, state IDLE.
2. Short packet: header 0x05 plus 4 bytes, then sending=0 → pkt_len=5, 5 bytes drained. With TRAN_TO_NET_PAD_SHORT_EN: 16 bytes drained, last 11 = 0x00, pkt_len=5.
3. Overflow: during DRAIN, hold sending=1 with data 0xFF → in_ready=0, buf_count unchanged, overflow=1 and stays 1 after the drain.
4. Underflow: net_rd=1 held 3 extra cycles after the FIFO empties → buf_count stays 0, no X on packet_out, no state change.
5. Reset mid-FILL: after 7 bytes, reset for 1 cycle → buf_count=0, buf_empty=1, send_data=0, pkt_len=0. A subsequent header 0x11 is accepted normally.
6. Back-to-back packets: a second burst (header 0x33) offered during DRAIN is refused (in_ready=0). Re-offered after the FIFO empties → accepted, phone_num=0x33.
